// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
//   Shared definitions for the i2c request arbiter: FSM state encoding,
//   the read/write direction value and the read data returned on a timeout.
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic       RW_READ   = 1'b1;
    localparam logic [7:0] RDATA_ERR = 8'hFF;

    // Width of the WAIT-state watchdog counter
    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/i2c_req_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. Scans the request vector starting at the
//   index just after the pointer (wrapping N_REQ-1 -> 0) and reports the
//   first asserted requester, both one-hot and as a binary index.
// Ports
//   req_i  in   N_REQ   request levels
//   ptr_i  in   IW      index of the last served requester
//   gnt_o  out  N_REQ   one-hot winner (all zero when nothing is requested)
//   idx_o  out  IW      binary index of the winner
//   vld_o  out  1       a winner exists
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             vld_o
);

    int k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        k     = 0;
        // Offsets 1..N_REQ: the pointer's own slot is visited last, so the
        // requester just served sits behind every other pending requester.
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(ptr_i) + i) % N_REQ;
            if (!vld_o && req_i[k]) begin
                vld_o    = 1'b1;
                idx_o    = IW'(k);
                gnt_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_req_arbiter
//   Shares one i2c_master between N_REQ requesters. A round-robin winner is
//   latched in IDLE, a single start pulse is issued, the sequencer waits for
//   a rising edge on the master's done level, then returns read data and a
//   one-cycle ack to the winner. IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Configuration
//   I2C_ARB_TIMEOUT_EN  when defined, a 16-bit watchdog runs in WAIT; after
//                       TIMEOUT_CYCLES WAIT cycles the transaction is closed
//                       with o_err=1 and o_rdata=8'hFF. When undefined, WAIT
//                       holds until done and o_err is tied low.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_req/_addr/_data/_rw     per-requester request level and fields
//                             (requester k at bits [8k+7:8k] of addr/data)
//   o_gnt                     one-hot grant, ISSUE through RESP
//   o_ack, o_err              one-cycle completion pulse / timeout flag
//   o_rdata                   read byte of the last completed read
//   o_busy                    sequencer not in IDLE
//   o_m_start/_addr/_data/_rw request to i2c_master (fields latched in IDLE)
//   i_m_done, i_m_data        completion level and read byte from master
// ---------------------------------------------------------------------------
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*8-1:0] i_req_addr,
    input  logic [N_REQ*8-1:0] i_req_data,
    input  logic [N_REQ-1:0]   i_req_rw,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [N_REQ-1:0]   o_ack,
    output logic [7:0]         o_rdata,
    output logic               o_err,
    output logic               o_busy,
    output logic               o_m_start,
    output logic [7:0]         o_m_addr,
    output logic [7:0]         o_m_data,
    output logic               o_m_rw,
    input  logic               i_m_done,
    input  logic [7:0]         i_m_data
);

    localparam int IW = $clog2(N_REQ);

    // Elaboration-time parameter range checks
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("i2c_req_arbiter: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TMO_CNT_W)) begin : g_bad_tmo
        $error("i2c_req_arbiter: TIMEOUT_CYCLES out of counter range");
    end

    arb_state_e       state_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    idx_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] ack_q;
    logic             start_q;
    logic [7:0]       rdata_q;
    logic [7:0]       m_addr_q;
    logic [7:0]       m_data_q;
    logic             m_rw_q;
    logic             done_q;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_vld;
    logic [7:0]       sel_addr;
    logic [7:0]       sel_data;
    logic             sel_rw;
    logic             done_rise;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    // Field mux for the current winner
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_rw   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_idx == IW'(k)) begin
                sel_addr = i_req_addr[8*k +: 8];
                sel_data = i_req_data[8*k +: 8];
                sel_rw   = i_req_rw[k];
            end
        end
    end

    // done_q follows the pin in every state, so the level seen during ISSUE
    // becomes the reference: a done still high from the previous operation
    // must fall and rise again before it can complete this one.
    assign done_rise = i_m_done & ~done_q;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_CNT_W-1:0] cnt_q;
    logic                 err_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IW'(N_REQ - 1);
            idx_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            start_q  <= 1'b0;
            rdata_q  <= '0;
            m_addr_q <= '0;
            m_data_q <= '0;
            m_rw_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            done_q  <= i_m_done;
            start_q <= 1'b0;
            ack_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (arb_vld) begin
                        m_addr_q <= sel_addr;
                        m_data_q <= sel_data;
                        m_rw_q   <= sel_rw;
                        idx_q    <= arb_idx;
                        gnt_q    <= arb_gnt;
                        start_q  <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_rise) begin
                        if (m_rw_q == RW_READ)
                            rdata_q <= i_m_data;
                        ack_q   <= gnt_q;
                        state_q <= ST_RESP;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    // Fires on the TIMEOUT_CYCLES-th WAIT cycle
                    else if (cnt_q == TMO_LAST) begin
                        rdata_q <= RDATA_ERR;
                        err_q   <= 1'b1;
                        ack_q   <= gnt_q;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    gnt_q   <= '0;
                    ptr_q   <= idx_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_gnt     = gnt_q;
    assign o_ack     = ack_q;
    assign o_rdata   = rdata_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_m_start = start_q;
    assign o_m_addr  = m_addr_q;
    assign o_m_data  = m_data_q;
    assign o_m_rw    = m_rw_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign o_err     = err_q;
`else
    assign o_err     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_req_arbiter.sv
module tb_i2c_req_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*8-1:0]   req_addr, req_data;
    logic [N-1:0]     req_rw;
    logic [N-1:0]     gnt, ack;
    logic [7:0]       rdata, m_addr, m_data, m_rdata;
    logic             err, busy, m_start, m_rw, m_done;

    always #5 clk = ~clk;

    i2c_req_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_addr(req_addr),
        .i_req_data(req_data), .i_req_rw(req_rw), .o_gnt(gnt), .o_ack(ack),
        .o_rdata(rdata), .o_err(err), .o_busy(busy), .o_m_start(m_start),
        .o_m_addr(m_addr), .o_m_data(m_data), .o_m_rw(m_rw),
        .i_m_done(m_done), .i_m_data(m_rdata)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one transaction record plus the round-robin
    // pointer. Each clock edge advances the transaction one step and the
    // expected outputs for the following cycle are compared 1 time unit
    // after the edge.
    // ------------------------------------------------------------------
    bit           mdl_on = 0;
    bit           in_txn, start_shown, ack_shown, prev_done, rise, found;
    int           owner, ptr, waited, w;
    logic [N-1:0] e_gnt, e_ack;
    logic [7:0]   e_rdata, e_maddr, e_mdata;
    logic         e_err, e_busy, e_start, e_mrw;

    always @(posedge clk) begin
        rise = m_done && !prev_done;
        if (rst) begin
            mdl_on = 1; in_txn = 0; start_shown = 0; ack_shown = 0;
            ptr = N - 1; owner = 0; waited = 0;
            e_gnt = '0; e_ack = '0; e_rdata = '0; e_maddr = '0; e_mdata = '0;
            e_err = 0; e_busy = 0; e_start = 0; e_mrw = 0;
        end else if (mdl_on) begin
            e_start = 0; e_ack = '0; e_err = 0;
            if (ack_shown) begin
                ack_shown = 0;
                e_gnt = '0;
            end else if (!in_txn) begin
                found = 0; w = 0;
                for (int i = 1; i <= N; i++)
                    if (!found && req[(ptr + i) % N]) begin
                        found = 1; w = (ptr + i) % N;
                    end
                if (found) begin
                    in_txn = 1; start_shown = 1; owner = w;
                    e_gnt = '0; e_gnt[w] = 1'b1; e_start = 1;
                    e_maddr = req_addr[8*w +: 8];
                    e_mdata = req_data[8*w +: 8];
                    e_mrw   = req_rw[w];
                end
            end else if (start_shown) begin
                start_shown = 0; waited = 0;
            end else begin
                waited++;
                if (rise) begin
                    if (e_mrw) e_rdata = m_rdata;
                    e_ack = '0; e_ack[owner] = 1'b1;
                    ptr = owner; in_txn = 0; ack_shown = 1;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (waited == TMO) begin
                    e_rdata = 8'hFF; e_err = 1;
                    e_ack = '0; e_ack[owner] = 1'b1;
                    ptr = owner; in_txn = 0; ack_shown = 1;
                end
`endif
            end
            e_busy = in_txn || ack_shown;
        end
        prev_done = rst ? 1'b0 : m_done;
        if (mdl_on) begin
            #1;
            chk("m_gnt",   gnt,     e_gnt);
            chk("m_ack",   ack,     e_ack);
            chk("m_rdata", rdata,   e_rdata);
            chk("m_err",   err,     e_err);
            chk("m_busy",  busy,    e_busy);
            chk("m_start", m_start, e_start);
            chk("m_addr",  m_addr,  e_maddr);
            chk("m_data",  m_data,  e_mdata);
            chk("m_rw",    m_rw,    e_mrw);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge only)
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_fields(input int k, input logic [7:0] a, input logic [7:0] d, input logic rw);
        req_addr[8*k +: 8] = a;
        req_data[8*k +: 8] = d;
        req_rw[k]          = rw;
    endtask

    // Returns at the falling edge where o_m_start is high
    task automatic wait_start(output int g);
        g = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_start) begin
                for (int k = 0; k < N; k++) if (gnt[k]) g = k;
                return;
            end
        end
        tests++; fails++;
        $display("FAIL wait_start: got no start pulse within 40 cycles, expected one");
    endtask

    // Serve a granted transaction with a clean done pulse
    task automatic serve(output int g, output logic [7:0] a);
        wait_start(g);
        a = m_addr;
        tick(); tick();
        m_done = 1'b1;
        tick();
        chk("serve_ack", ack, (g >= 0) ? (32'd1 << g) : 32'd0);
        m_done = 1'b0;
    endtask

    int         g, cyc;
    logic [7:0] a;

    initial begin
        rst = 1'b1; req = '1; req_addr = 32'h44332211; req_data = 32'h88776655;
        req_rw = '1; m_done = 1'b0; m_rdata = 8'h00;

        // 1: reset with requests high
        repeat (2) tick();
        chk("rst_gnt", gnt, 0);   chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0); chk("rst_start", m_start, 0);
        chk("rst_rdata", rdata, 0); chk("rst_err", err, 0);
        chk("rst_maddr", m_addr, 0);

        // 2: single read on requester 0
        rst = 1'b0; req = 4'b0001; set_fields(0, 8'hB7, 8'h00, 1'b1);
        tick();
        chk("t2_start", m_start, 1); chk("t2_maddr", m_addr, 8'hB7);
        chk("t2_mrw", m_rw, 1);      chk("t2_gnt", gnt, 4'b0001);
        req = '0;
        tick();
        chk("t2_start_1cyc", m_start, 0);
        tick();
        m_done = 1'b1; m_rdata = 8'h2E;
        tick();
        chk("t2_ack", ack, 4'b0001); chk("t2_rdata", rdata, 8'h2E);
        m_done = 1'b0; m_rdata = 8'h00;
        tick();
        chk("t2_ack_1cyc", ack, 0); chk("t2_idle", busy, 0);

        // 3: contention from a fresh reset, all writes
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < N; k++) set_fields(k, 8'h10 + 8'(k), 8'hA0 + 8'(k), 1'b0);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            if (j == 4) begin
                wait_start(g); req = '0; a = m_addr;
                tick(); tick(); m_done = 1'b1; tick();
                chk("serve_ack", ack, (g >= 0) ? (32'd1 << g) : 32'd0);
                m_done = 1'b0;
            end else serve(g, a);
            chk("t3_order", g, j % 4);
            chk("t3_addr", a, 8'h10 + 8'(j % 4));
        end
        tick(); tick();
        chk("t3_rdata_kept", rdata, 0);

        // 4: read, then write that leaves done high, then stale-done check
        set_fields(3, 8'h33, 8'h00, 1'b1); req = 4'b1000;
        wait_start(g); req = '0; tick();
        m_done = 1'b1; m_rdata = 8'h5A; tick();
        chk("t4_rd_ack", ack, 4'b1000); chk("t4_rd_data", rdata, 8'h5A);
        m_done = 1'b0; tick();
        set_fields(2, 8'h22, 8'h99, 1'b0); req = 4'b0100;
        wait_start(g); req = '0; tick();
        m_done = 1'b1; m_rdata = 8'h77; tick();
        chk("t4_wr_ack", ack, 4'b0100); chk("t4_wr_rdata_kept", rdata, 8'h5A);
        set_fields(1, 8'h11, 8'h00, 1'b1); req = 4'b0010;
        wait_start(g); req = '0;
        chk("t4_gnt1", g, 1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t4_stale_noack", ack, 0); chk("t4_stale_busy", busy, 1);
        end
        m_done = 1'b0; tick();
        m_done = 1'b1; m_rdata = 8'hC3; tick();
        chk("t4_late_ack", ack, 4'b0010); chk("t4_late_rdata", rdata, 8'hC3);
        m_done = 1'b0; tick();

        // 5: reset in the middle of WAIT
        set_fields(0, 8'h01, 8'h00, 1'b1); req = 4'b0001;
        wait_start(g); req = '0; tick(); tick();
        rst = 1'b1; tick();
        chk("t5_busy", busy, 0); chk("t5_gnt", gnt, 0); chk("t5_start", m_start, 0);
        rst = 1'b0; m_done = 1'b1; tick();
        chk("t5_noack", ack, 0);
        m_done = 1'b0; tick();
        set_fields(0, 8'h5C, 8'h00, 1'b0); req = 4'b0001;
        wait_start(g); req = '0;
        chk("t5_regrant", g, 0); chk("t5_maddr", m_addr, 8'h5C);
        tick(); m_done = 1'b1; tick();
        chk("t5_ack", ack, 4'b0001);
        m_done = 1'b0; tick();

        // 6: master never answers
        set_fields(2, 8'h66, 8'h00, 1'b1); req = 4'b0100;
        wait_start(g); req = '0;
`ifdef I2C_ARB_TIMEOUT_EN
        cyc = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (cyc < 0 && ack != '0) begin
                cyc = c;
                chk("t6_ack", ack, 4'b0100); chk("t6_err", err, 1);
                chk("t6_rdata", rdata, 8'hFF);
            end
        end
        chk("t6_ack_cycle", cyc, TMO + 1);
`else
        cyc = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (busy && !err) cyc++;
        end
        chk("t6_hold_cycles", cyc, 40);
        m_done = 1'b1; tick();
        chk("t6_late_ack", ack, 4'b0100);
        m_done = 1'b0;
`endif
        tick(); tick();

        // Random traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            req      = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
            req_addr = $urandom;
            req_data = $urandom;
            req_rw   = N'($urandom);
            if ($urandom_range(0, 3) == 0) m_done = ~m_done;
            m_rdata  = 8'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; req = '0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
